// File: rtl/clk_div_ctrl.sv
// Ratio-change sequencer for a programmable half-step clock divider.
// Stops the divider, waits for it to drain, loads the new ratio, restarts it,
// then confirms lock by counting divider output edges fed back on div_fb.
module clk_div_ctrl #(
   parameter int unsigned RATIO_W        = 4,
   parameter int unsigned DEFAULT_RATIO  = 9,
   parameter int unsigned DRAIN_CYCLES   = 4,
   parameter int unsigned LOCK_EDGES     = 3,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_valid,
   input  logic [RATIO_W-1:0] cfg_ratio,
   output logic               cfg_ready,
   output logic               div_enable,
   output logic [RATIO_W-1:0] div_ratio,
   input  logic               div_fb,
   output logic               busy,
   output logic               locked,
   output logic               err_illegal,
   output logic               err_timeout
);

   localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);
   localparam int unsigned EDGE_W  = $clog2(LOCK_EDGES + 1);
   localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      STOP  = 3'd1,
      LOAD  = 3'd2,
      START = 3'd3,
      LOCK  = 3'd4
   } state_t;

   state_t               state, state_nx;
   logic [RATIO_W-1:0]   req_ratio, req_ratio_nx;
   logic [DRAIN_W-1:0]   drain_cnt, drain_cnt_nx;
   logic [EDGE_W-1:0]    edge_cnt, edge_cnt_nx;
   logic [TMO_W-1:0]     tmo_cnt, tmo_cnt_nx;
   logic                 cfg_ready_nx, div_enable_nx, busy_nx, locked_nx;
   logic                 err_illegal_nx, err_timeout_nx;
   logic [RATIO_W-1:0]   div_ratio_nx;
   logic                 fb_s1, fb_s2, fb_s3;
   logic                 fb_rise;

   // div_fb is asynchronous: two-flop synchroniser plus a history flop for edge detect
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fb_s1 <= 1'b0;
         fb_s2 <= 1'b0;
         fb_s3 <= 1'b0;
      end else begin
         fb_s1 <= div_fb;
         fb_s2 <= fb_s1;
         fb_s3 <= fb_s2;
      end
   end

   assign fb_rise = fb_s2 & ~fb_s3;

   // State, counters and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         req_ratio   <= '0;
         drain_cnt   <= '0;
         edge_cnt    <= '0;
         tmo_cnt     <= '0;
         cfg_ready   <= 1'b1;
         div_enable  <= 1'b0;
         div_ratio   <= RATIO_W'(DEFAULT_RATIO);
         busy        <= 1'b0;
         locked      <= 1'b0;
         err_illegal <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_nx;
         req_ratio   <= req_ratio_nx;
         drain_cnt   <= drain_cnt_nx;
         edge_cnt    <= edge_cnt_nx;
         tmo_cnt     <= tmo_cnt_nx;
         cfg_ready   <= cfg_ready_nx;
         div_enable  <= div_enable_nx;
         div_ratio   <= div_ratio_nx;
         busy        <= busy_nx;
         locked      <= locked_nx;
         err_illegal <= err_illegal_nx;
         err_timeout <= err_timeout_nx;
      end
   end

   // Next state; outputs are computed for the state being entered
   always_comb begin
      state_nx       = state;
      req_ratio_nx   = req_ratio;
      drain_cnt_nx   = drain_cnt;
      edge_cnt_nx    = edge_cnt;
      tmo_cnt_nx     = tmo_cnt;
      cfg_ready_nx   = cfg_ready;
      div_enable_nx  = div_enable;
      div_ratio_nx   = div_ratio;
      busy_nx        = busy;
      locked_nx      = locked;
      err_illegal_nx = 1'b0;
      err_timeout_nx = err_timeout;

      case (state)
         IDLE: begin
            if (cfg_valid) begin
               req_ratio_nx = cfg_ratio;
               if (cfg_ratio == RATIO_W'(1)) begin
                  err_illegal_nx = 1'b1;
               end else begin
                  err_timeout_nx = 1'b0;
                  locked_nx      = 1'b0;
                  div_enable_nx  = 1'b0;
                  drain_cnt_nx   = '0;
                  cfg_ready_nx   = 1'b0;
                  busy_nx        = 1'b1;
                  state_nx       = STOP;
               end
            end
         end
         STOP: begin
            if (drain_cnt >= DRAIN_W'(DRAIN_CYCLES - 1)) begin
               div_ratio_nx = req_ratio;
               state_nx     = LOAD;
            end else begin
               drain_cnt_nx = drain_cnt + DRAIN_W'(1);
            end
         end
         LOAD: begin
            if (req_ratio == '0) begin
               div_enable_nx = 1'b0;
               locked_nx     = 1'b0;
               cfg_ready_nx  = 1'b1;
               busy_nx       = 1'b0;
               state_nx      = IDLE;
            end else begin
               div_enable_nx = 1'b1;
               edge_cnt_nx   = '0;
               tmo_cnt_nx    = '0;
               state_nx      = START;
            end
         end
         START: begin
            state_nx = LOCK;
         end
         LOCK: begin
            if (fb_rise && (edge_cnt < EDGE_W'(LOCK_EDGES)))
               edge_cnt_nx = edge_cnt + EDGE_W'(1);
            if (tmo_cnt < TMO_W'(TIMEOUT_CYCLES))
               tmo_cnt_nx = tmo_cnt + TMO_W'(1);
            // Lock takes priority over a timeout landing on the same cycle
            if (fb_rise && (edge_cnt >= EDGE_W'(LOCK_EDGES - 1))) begin
               locked_nx    = 1'b1;
               cfg_ready_nx = 1'b1;
               busy_nx      = 1'b0;
               state_nx     = IDLE;
            end else if (tmo_cnt >= TMO_W'(TIMEOUT_CYCLES - 1)) begin
               err_timeout_nx = 1'b1;
               locked_nx      = 1'b0;
               cfg_ready_nx   = 1'b1;
               busy_nx        = 1'b0;
               state_nx       = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: table of ratio requests checked through a scoreboard,
// plus hand sequences for latency, hold-off and asynchronous reset.
module tb_clk_div_ctrl;

   localparam int unsigned RATIO_W        = 4;
   localparam int unsigned DEFAULT_RATIO  = 9;
   localparam int unsigned DRAIN_CYCLES   = 4;
   localparam int unsigned LOCK_EDGES     = 3;
   localparam int unsigned TIMEOUT_CYCLES = 64;

   logic               clk = 1'b0;
   logic               reset;
   logic               cfg_valid;
   logic [RATIO_W-1:0] cfg_ratio;
   logic               cfg_ready;
   logic               div_enable;
   logic [RATIO_W-1:0] div_ratio;
   logic               div_fb;
   logic               busy;
   logic               locked;
   logic               err_illegal;
   logic               err_timeout;

   int errs   = 0;
   int checks = 0;

   logic fb_on = 1'b1;

   clk_div_ctrl #(
      .RATIO_W(RATIO_W), .DEFAULT_RATIO(DEFAULT_RATIO), .DRAIN_CYCLES(DRAIN_CYCLES),
      .LOCK_EDGES(LOCK_EDGES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ratio(cfg_ratio),
      .cfg_ready(cfg_ready), .div_enable(div_enable), .div_ratio(div_ratio),
      .div_fb(div_fb), .busy(busy), .locked(locked),
      .err_illegal(err_illegal), .err_timeout(err_timeout)
   );

   always #50 clk = ~clk;

   // Divider model: output period = ratio/2 clk periods; edges offset from clk edges
   initial begin
      div_fb = 1'b0;
      #3;
      forever begin
         if (fb_on && div_enable && (div_ratio >= 4'd2)) begin
            #(int'(div_ratio) * 25);
            if (fb_on && div_enable) div_fb = ~div_fb;
            else                     div_fb = 1'b0;
         end else begin
            div_fb = 1'b0;
            #10;
         end
      end
   end

   // Reference edge counter: synchronised rises and cycles seen after the first enabled busy cycle
   logic m1 = 1'b0, m2 = 1'b0, m3 = 1'b0;
   logic in_lock = 1'b0;
   int   mcnt = 0;
   int   lcyc = 0;
   always @(posedge clk) begin
      if (busy && div_enable) begin
         in_lock <= 1'b1;
         if (in_lock) begin
            lcyc <= lcyc + 1;
            if (m2 && !m3) mcnt <= mcnt + 1;
         end
      end else begin
         in_lock <= 1'b0;
         lcyc    <= 0;
         mcnt    <= 0;
      end
      m1 <= div_fb;
      m2 <= m1;
      m3 <= m2;
   end

   typedef struct {
      logic [RATIO_W-1:0] ratio;
      bit                 fb;
      bit                 ready1;
      bit                 illegal1;
      bit                 en;
      logic [RATIO_W-1:0] rat;
      bit                 lk;
      bit                 tmo;
   } vec_t;

   vec_t vecs[9];
   vec_t sb[$];

   logic [RATIO_W-1:0] prev_ratio;
   logic               prev_en;
   bit                 mon_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance to the next falling edge; div_ratio may only move while the divider is stopped
   task automatic tick();
      @(negedge clk);
      if (mon_on && !reset && (div_ratio !== prev_ratio))
         chk("ratio_moved_while_enabled", {30'b0, prev_en, div_enable}, 32'd0);
      prev_ratio = div_ratio;
      prev_en    = div_enable;
   endtask

   task automatic wait_idle(input string name, input int bound);
      int n = 0;
      while ((cfg_ready !== 1'b1) && (n < bound)) begin
         tick();
         n++;
      end
      chk({"idle_", name}, cfg_ready, 1);
   endtask

   // Drive one request; returns on the falling edge of the first cycle after acceptance
   task automatic send(input logic [RATIO_W-1:0] r);
      tick();
      cfg_valid = 1'b1;
      cfg_ratio = r;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_cfg_ready"},   cfg_ready,   1);
      chk({tag, "_div_enable"},  div_enable,  0);
      chk({tag, "_div_ratio"},   div_ratio,   DEFAULT_RATIO);
      chk({tag, "_busy"},        busy,        0);
      chk({tag, "_locked"},      locked,      0);
      chk({tag, "_err_illegal"}, err_illegal, 0);
      chk({tag, "_err_timeout"}, err_timeout, 0);
   endtask

   // Per-cycle enable/ratio timeline after accept at edge T, then lock confirmation
   task automatic lat_seq(input string tag, input logic [RATIO_W-1:0] r,
                          input logic [RATIO_W-1:0] old);
      send(r);
      chk({tag, "_ready_t1"}, cfg_ready, 0);
      chk({tag, "_busy_t1"},  busy,      1);
      for (int k = 1; k <= 6; k++) begin
         chk($sformatf("%s_en_t%0d", tag, k), div_enable, (k >= 6) ? 1 : 0);
         chk($sformatf("%s_ratio_t%0d", tag, k), div_ratio, (k >= 5) ? r : old);
         if (k < 6) tick();
      end
      wait_idle(tag, 400);
      chk({tag, "_locked"},    locked,      1);
      chk({tag, "_rises"},     mcnt,        LOCK_EDGES);
      chk({tag, "_timeout"},   err_timeout, 0);
      chk({tag, "_ratio_end"}, div_ratio,   r);
   endtask

   initial begin
      #(100 * 20000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t e;
      int   n;

      vecs[0] = '{4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0};
      vecs[1] = '{4'd1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0};
      vecs[2] = '{4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
      vecs[3] = '{4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
      vecs[4] = '{4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
      vecs[5] = '{4'd9, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b1};
      vecs[6] = '{4'd6, 1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0};
      vecs[7] = '{4'd8, 1'b1, 1'b0, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0};
      vecs[8] = '{4'd8, 1'b1, 1'b0, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0};

      reset     = 1'b1;
      cfg_valid = 1'b0;
      cfg_ratio = '0;
      repeat (3) @(negedge clk);
      chk_reset("por");
      #10 reset = 1'b0;
      prev_ratio = div_ratio;
      prev_en    = div_enable;
      mon_on     = 1'b1;
      tick();
      chk_reset("post_rel");

      // Request 9 out of reset
      lat_seq("seq9", 4'd9, 4'd9);

      // Table of requests through the scoreboard
      for (int i = 0; i < 9; i++) begin
         fb_on = vecs[i].fb;
         send(vecs[i].ratio);
         sb.push_back(vecs[i]);
         chk($sformatf("v%0d_ready_t1", i),   cfg_ready,   sb[0].ready1);
         chk($sformatf("v%0d_illegal_t1", i), err_illegal, sb[0].illegal1);
         chk($sformatf("v%0d_tmo_t1", i),     err_timeout, 0);
         if (sb[0].illegal1) begin
            tick();
            chk($sformatf("v%0d_illegal_t2", i), err_illegal, 0);
            chk($sformatf("v%0d_ready_t2", i),   cfg_ready,   1);
         end else begin
            wait_idle($sformatf("v%0d", i), 400);
         end
         e = sb.pop_front();
         chk($sformatf("v%0d_en", i),     div_enable,  e.en);
         chk($sformatf("v%0d_ratio", i),  div_ratio,   e.rat);
         chk($sformatf("v%0d_locked", i), locked,      e.lk);
         chk($sformatf("v%0d_tmo", i),    err_timeout, e.tmo);
         chk($sformatf("v%0d_busy", i),   busy,        0);
         if (e.lk && !e.illegal1) chk($sformatf("v%0d_rises", i), mcnt, LOCK_EDGES);
         if (e.tmo) chk($sformatf("v%0d_lock_cycles", i), lcyc, TIMEOUT_CYCLES);
      end
      fb_on = 1'b1;

      // Ratio change 8 -> 10, visible timeline
      lat_seq("seq10", 4'd10, 4'd8);

      // Request held while busy is accepted on the first idle cycle
      tick();
      cfg_valid = 1'b1;
      cfg_ratio = 4'd12;
      tick();
      cfg_ratio = 4'd6;
      chk("hold_ready_t1", cfg_ready, 0);
      n = 0;
      while ((cfg_ready !== 1'b1) && (n < 400)) begin
         tick();
         n++;
      end
      chk("hold_first_idle", cfg_ready, 1);
      chk("hold_ratio_12",   div_ratio, 12);
      chk("hold_locked_12",  locked,    1);
      tick();
      cfg_valid = 1'b0;
      chk("hold_accepted_ready", cfg_ready, 0);
      chk("hold_accepted_busy",  busy,      1);
      wait_idle("hold6", 400);
      chk("hold_ratio_6",  div_ratio, 6);
      chk("hold_locked_6", locked,    1);
      chk("hold_rises_6",  mcnt,      LOCK_EDGES);

      // Reset during STOP
      send(4'd4);
      tick();
      chk("rst_stop_busy", busy, 1);
      reset = 1'b1;
      #1;
      chk_reset("rst_stop");
      tick();
      #10 reset = 1'b0;

      // Reset during LOCK
      send(4'd9);
      n = 0;
      while ((div_enable !== 1'b1) && (n < 50)) begin
         tick();
         n++;
      end
      chk("rst_lock_enable_up", div_enable, 1);
      repeat (3) tick();
      chk("rst_lock_busy",   busy,   1);
      chk("rst_lock_locked", locked, 0);
      reset = 1'b1;
      #1;
      chk_reset("rst_lock");
      tick();
      #10 reset = 1'b0;

      // Normal completion after reset
      send(4'd6);
      chk("after_rst_ready_t1", cfg_ready, 0);
      wait_idle("after_rst", 400);
      chk("after_rst_locked", locked,      1);
      chk("after_rst_ratio",  div_ratio,   6);
      chk("after_rst_rises",  mcnt,        LOCK_EDGES);
      chk("after_rst_tmo",    err_timeout, 0);

      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
